trace_vector_packer: RTL and testbench
======================================

Name: trace_vector_packer

Overview:
Writer-side front end for the input buffer queue. Accepts one DATA_WIDTH trace sample per cycle and packs N samples into one vector, lane 0 first. Emits each full vector, or a partial vector when eof is seen, as a single-cycle enqueue pulse. Credit-based flow control sized to IB_DEPTH keeps the downstream queue from overflowing.

Parameters:
N, 8, lanes per vector (power of two not required, N>=2)
DATA_WIDTH, 32, bits per lane
IB_DEPTH, 4, downstream queue depth; initial credit count

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
valid_in  in  1  sample present on data_in
eof_in  in  1  sample is last of the frame; qualified by valid_in
data_in  in  DATA_WIDTH  trace sample
ready_out  out  1  packer can accept a sample this cycle
credit_return  in  1  downstream dequeued one vector; one credit returned per cycle high
enqueue  out  1  one-cycle pulse: vector_out/eof_out valid
eof_out  out  1  emitted vector closes a frame
vector_out  out  DATA_WIDTH x [N-1:0]  unpacked array, lane i = i-th accepted sample
credits  out  $clog2(IB_DEPTH+1)  free downstream slots
credit_err  out  1  sticky: credit_return received with credits==IB_DEPTH

Behaviour:
- Reset (async, rstn low): enqueue=0, eof_out=0, vector_out all lanes 0, lane index=0, accumulator cleared, credits=IB_DEPTH, credit_err=0. Partial vector in progress is discarded.
- ready_out = (credits != 0), combinational from registered credits only; never depends on valid_in/eof_in.
- Accept = valid_in & ready_out. Sample written into accumulator lane [idx]; idx increments.
- Completing beat = accepted sample with idx==N-1 or eof_in=1.
  - On its edge: accumulator (including this sample) copied to output register; lanes above idx forced to 0 (padding); eof_out <= eof_in; enqueue <= 1; accumulator cleared, idx <= 0; credits decremented.
  - Latency: completing beat at edge k -> enqueue high for exactly cycle k..k+1 (one cycle after acceptance).
- Non-completing beat: enqueue <= 0. When nothing is accepted, enqueue <= 0 and vector_out holds its last value.
- Back-to-back: separate accumulator and output registers. A new frame's lane 0 is accepted in the same cycle enqueue is high, so throughput is 1 sample/cycle while credits last.
- Credits, arithmetic:
  - Decrement on completing beat, increment on credit_return.
  - Both in the same cycle: unchanged.
  - credit_return alone at credits==IB_DEPTH: ignored, credit_err <= 1 (sticky until reset).
  - Decrement is impossible at 0 because ready_out is low.
- ready_out low mid-vector: idx and accumulator hold. valid_in is ignored, so the upstream must hold or drop the sample.
- eof_in on lane 0: vector = {sample, 0...}, eof_out=1.
- eof_in without valid_in: ignored.
- idx counter width $clog2(N); wraps only via the completing beat.

Optional Feature:
TRACE_PACKER_STATS_EN
- Defined:
  - Adds output vec_count (32 bit): counts enqueue pulses, wraps at 2^32.
  - Adds output pad_count (32 bit): sums padded lanes of partial vectors.
  - Both reset to 0 on rstn.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Full vector: N=8, IB_DEPTH=4, 8 consecutive valid samples 1..8, eof=0 -> enqueue high one cycle after 8th accept, vector_out={1..8} lane0=1, eof_out=0, credits 4->3.
- Partial eof: samples 0xA,0xB,0xC, third with eof_in=1 -> lanes 0..2=A,B,C, lanes 3..7=0, eof_out=1, idx back to 0 (next sample lands in lane 0).
- Backpressure: no credit_return, stream 40 samples -> 4 enqueues, then ready_out=0 and credits=0. One credit_return -> ready_out=1 next cycle, fifth vector emitted after 8 more accepts.
- Simultaneous: completing beat and credit_return in the same cycle at credits=2 -> credits stays 2. Then credit_return at credits=4 -> credit_err=1, credits=4.
- Reset mid-vector: 5 samples accepted, rstn pulsed low asynchronously -> enqueue=0, credits=4. The next 8 samples form a clean vector with no stale lanes.
- Stats (TRACE_PACKER_STATS_EN): one full vector plus one 3-sample eof vector -> vec_count=2, pad_count=5.

Source files
------------

// File: rtl/trace_vector_packer.sv
// trace_vector_packer: writer-side front end for the input buffer queue.
// Packs N DATA_WIDTH samples (lane 0 first) into one vector and emits it as a
// single-cycle enqueue pulse. Partial vectors are closed early by eof_in and
// zero-padded. Credit-based flow control, sized to IB_DEPTH, stops the
// downstream queue from overflowing.
// Optional statistics counters: define TRACE_PACKER_STATS_EN.

module trace_vector_packer #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IB_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            valid_in,
  input  logic                            eof_in,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic                            ready_out,
  input  logic                            credit_return,
  output logic                            enqueue,
  output logic                            eof_out,
  output logic [DATA_WIDTH-1:0]           vector_out [N-1:0],
  output logic [$clog2(IB_DEPTH+1)-1:0]   credits,
  output logic                            credit_err
`ifdef TRACE_PACKER_STATS_EN
  ,
  output logic [31:0]                     vec_count,
  output logic [31:0]                     pad_count
`endif
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned CredW = $clog2(IB_DEPTH + 1);

  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(N - 1);
  localparam logic [CredW-1:0] MaxCredits = CredW'(IB_DEPTH);

  // Accumulator (vector being built) and output register are separate so a
  // new frame can start while the previous vector is being enqueued.
  logic [IdxW-1:0]       r_idx;
  logic [DATA_WIDTH-1:0] r_acc [N-1:0];
  logic [DATA_WIDTH-1:0] r_vec [N-1:0];
  logic                  r_enq;
  logic                  r_eof;
  logic [CredW-1:0]      r_credits;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last_lane;
  logic                  w_complete;
  logic [IdxW-1:0]       w_idx_next;
  logic [DATA_WIDTH-1:0] w_acc_next [N-1:0];
  logic [DATA_WIDTH-1:0] w_vec_next [N-1:0];
  logic [CredW-1:0]      w_credits_next;
  logic                  w_err_next;

  // Handshake decode; ready depends on registered credits only.
  always_comb begin
    w_ready     = (r_credits != '0);
    w_accept    = valid_in & w_ready;
    w_last_lane = (r_idx == LastIdx);
    w_complete  = w_accept & (w_last_lane | eof_in);
  end

  // Accumulator and lane index next state.
  always_comb begin
    w_acc_next = r_acc;
    w_idx_next = r_idx;
    if (w_complete) begin
      for (int i = 0; i < int'(N); i++) begin
        w_acc_next[i] = '0;
      end
      w_idx_next = '0;
    end else if (w_accept) begin
      w_acc_next[r_idx] = data_in;
      w_idx_next        = r_idx + IdxW'(1);
    end
  end

  // Vector to emit on a completing beat: earlier lanes from the accumulator,
  // current lane from data_in, everything above it padded with zeros.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      if (IdxW'(i) < r_idx) begin
        w_vec_next[i] = r_acc[i];
      end else if (IdxW'(i) == r_idx) begin
        w_vec_next[i] = data_in;
      end else begin
        w_vec_next[i] = '0;
      end
    end
  end

  // Credit arithmetic; a simultaneous spend and return cancel out.
  always_comb begin
    w_credits_next = r_credits;
    w_err_next     = r_err;
    case ({w_complete, credit_return})
      2'b10: w_credits_next = r_credits - CredW'(1);
      2'b01: begin
        if (r_credits == MaxCredits) begin
          // Return with no outstanding vector: drop it and flag.
          w_err_next = 1'b1;
        end else begin
          w_credits_next = r_credits + CredW'(1);
        end
      end
      default: ;
    endcase
  end

  // Accumulator and lane index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_idx <= w_idx_next;
      r_acc <= w_acc_next;
    end
  end

  // Output register: enqueue pulses for one cycle, vector holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_enq <= 1'b0;
      r_eof <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_vec[i] <= '0;
      end
    end else begin
      r_enq <= w_complete;
      if (w_complete) begin
        r_vec <= w_vec_next;
        r_eof <= eof_in;
      end
    end
  end

  // Credit counter and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_credits <= MaxCredits;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_credits_next;
      r_err     <= w_err_next;
    end
  end

  // Output drive.
  always_comb begin
    ready_out  = w_ready;
    enqueue    = r_enq;
    eof_out    = r_eof;
    vector_out = r_vec;
    credits    = r_credits;
    credit_err = r_err;
  end

`ifdef TRACE_PACKER_STATS_EN
  logic [31:0] r_vec_count;
  logic [31:0] r_pad_count;

  // Statistics: vectors emitted and total padded lanes (full vectors add 0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vec_count <= '0;
      r_pad_count <= '0;
    end else if (w_complete) begin
      r_vec_count <= r_vec_count + 32'd1;
      r_pad_count <= r_pad_count + (32'(N - 1) - 32'(r_idx));
    end
  end

  // Statistics output drive.
  always_comb begin
    vec_count = r_vec_count;
    pad_count = r_pad_count;
  end
`endif

endmodule

// File: tb/tb_trace_vector_packer.sv
// Self-checking bench for trace_vector_packer (N=8, DATA_WIDTH=32, IB_DEPTH=4).
// A small reference model predicts each emitted vector and pushes it to a
// scoreboard queue; vectors are popped and compared when enqueue is seen.

module tb_trace_vector_packer;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IB = 4;
  localparam int unsigned CW = $clog2(IB + 1);

  typedef struct packed {
    logic                 eof;
    logic [N-1:0][DW-1:0] lanes;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          valid_in;
  logic          eof_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          credit_return;
  logic          enqueue;
  logic          eof_out;
  logic [DW-1:0] vector_out [N-1:0];
  logic [CW-1:0] credits;
  logic          credit_err;
`ifdef TRACE_PACKER_STATS_EN
  logic [31:0]   vec_count;
  logic [31:0]   pad_count;
`endif

  trace_vector_packer #(
    .N          (N),
    .DATA_WIDTH (DW),
    .IB_DEPTH   (IB)
  ) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .valid_in      (valid_in),
    .eof_in        (eof_in),
    .data_in       (data_in),
    .ready_out     (ready_out),
    .credit_return (credit_return),
    .enqueue       (enqueue),
    .eof_out       (eof_out),
    .vector_out    (vector_out),
    .credits       (credits),
    .credit_err    (credit_err)
`ifdef TRACE_PACKER_STATS_EN
    ,
    .vec_count     (vec_count),
    .pad_count     (pad_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state.
  exp_t          sb_q [$];
  logic [DW-1:0] m_lanes [N];
  logic [DW-1:0] m_last  [N];
  int            m_idx;
  int            m_cred;
  logic          m_err;
  int            m_vcnt;
  int            m_pcnt;
  logic [DW-1:0] sample;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_lanes[i] = '0;
      m_last[i]  = '0;
    end
    m_idx  = 0;
    m_cred = IB;
    m_err  = 1'b0;
    m_vcnt = 0;
    m_pcnt = 0;
    sb_q.delete();
  endtask

  task automatic check_vector(input string tag);
    for (int i = 0; i < int'(N); i++) begin
      check_val($sformatf("%s_lane%0d", tag, i), 64'(vector_out[i]), 64'(m_last[i]));
    end
  endtask

  // One clock: drive inputs just after a negedge, update the model, then
  // check outputs 1 time unit after the rising edge. Ends on the next negedge.
  task automatic tick(input logic v, input logic e, input logic [DW-1:0] d, input logic cr);
    logic acc;
    logic done;
    exp_t ex;
    exp_t got;
    valid_in      = v;
    eof_in        = e;
    data_in       = d;
    credit_return = cr;
    #1;
    check_val("ready", 64'(ready_out), 64'(m_cred != 0));
    acc  = v && (m_cred != 0);
    done = acc && ((m_idx == int'(N) - 1) || e);
    if (acc) m_lanes[m_idx] = d;
    if (done) begin
      ex.eof = e;
      for (int i = 0; i < int'(N); i++) ex.lanes[i] = (i <= m_idx) ? m_lanes[i] : '0;
      sb_q.push_back(ex);
      m_vcnt++;
      m_pcnt += int'(N) - 1 - m_idx;
      for (int i = 0; i < int'(N); i++) m_lanes[i] = '0;
      m_idx = 0;
    end else if (acc) begin
      m_idx++;
    end
    if (done && !cr) m_cred--;
    else if (cr && !done) begin
      if (m_cred == int'(IB)) m_err = 1'b1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
    check_val("enqueue", 64'(enqueue), 64'(done));
    if (enqueue === 1'b1 && sb_q.size() > 0) begin
      got = sb_q.pop_front();
      for (int i = 0; i < int'(N); i++) m_last[i] = got.lanes[i];
      check_val("eof_out", 64'(eof_out), 64'(got.eof));
    end
    check_vector("vec");
    check_val("credits", 64'(credits), 64'(m_cred));
    check_val("credit_err", 64'(credit_err), 64'(m_err));
    @(negedge clk);
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic apply_reset();
    valid_in      = 1'b0;
    eof_in        = 1'b0;
    data_in       = '0;
    credit_return = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_val("rst_enqueue", 64'(enqueue), 64'(0));
    check_val("rst_credits", 64'(credits), 64'(IB));
    check_val("rst_credit_err", 64'(credit_err), 64'(0));
    check_val("rst_eof_out", 64'(eof_out), 64'(0));
    check_vector("rst_vec");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rstn          = 1'b0;
    valid_in      = 1'b0;
    eof_in        = 1'b0;
    data_in       = '0;
    credit_return = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();
    check_val("rst_ready", 64'(ready_out), 64'(1));

    // Full vector 1..8.
    for (int i = 1; i <= 8; i++) tick(1'b1, 1'b0, DW'(i), 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);

    // Partial eof vector A,B,C; then eof on lane 0.
    tick(1'b1, 1'b0, 32'hA, 1'b0);
    tick(1'b1, 1'b0, 32'hB, 1'b0);
    tick(1'b1, 1'b1, 32'hC, 1'b0);
    tick(1'b1, 1'b1, 32'h55, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);

    // Backpressure: 40 offered samples, only 32 fit in 4 credits.
    sample = 32'h100;
    for (int i = 0; i < 40; i++) begin
      if (m_cred != 0) begin
        tick(1'b1, 1'b0, sample, 1'b0);
        sample++;
      end else begin
        tick(1'b1, 1'b0, 32'hDEAD0000 + DW'(i), 1'b0);
      end
    end
    check_val("bp_ready_low", 64'(ready_out), 64'(0));
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, sample, 1'b0);
      sample++;
    end

    // Completing beat with simultaneous credit return at credits=2.
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, $urandom, 1'b0);
    tick(1'b1, 1'b0, $urandom, 1'b1);
    check_val("simul_credits", 64'(credits), 64'(2));
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    check_val("overflow_err", 64'(credit_err), 64'(1));

    // eof without valid is ignored; two-lane frame follows.
    tick(1'b0, 1'b1, 32'h66, 1'b0);
    tick(1'b1, 1'b0, 32'h77, 1'b0);
    tick(1'b1, 1'b1, 32'h78, 1'b0);

    // Reset mid-vector, then a clean vector.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'hBAD0 + DW'(i), 1'b0);
    apply_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'h300 + DW'(i), 1'b0);

    // Statistics: one full vector plus one 3-sample eof vector.
    apply_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'h400 + DW'(i), 1'b0);
    tick(1'b1, 1'b0, 32'h501, 1'b0);
    tick(1'b1, 1'b0, 32'h502, 1'b0);
    tick(1'b1, 1'b1, 32'h503, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
`ifdef TRACE_PACKER_STATS_EN
    check_val("vec_count", 64'(vec_count), 64'(m_vcnt));
    check_val("pad_count", 64'(pad_count), 64'(m_pcnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
